// File: rtl/led_run_ctrl.sv
// led_run_ctrl: conditions two raw push keys (synchronise + debounce + press
// edge) and drives a one-hot running light through a four-state FSM
// (idle, run left, run right, pause). led and state are registered.
module led_run_ctrl #(
    parameter int LED_W       = 10,
    parameter int DB_CYCLES   = 500000,
    parameter int STEP_CYCLES = 5000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       key,
    output logic [LED_W-1:0] led,
    output logic [1:0]       state
);

    localparam int DB_W = $clog2(DB_CYCLES + 1);
    localparam int ST_W = $clog2(STEP_CYCLES);

    localparam logic [DB_W-1:0]  DB_ZERO   = {DB_W{1'b0}};
    localparam logic [DB_W-1:0]  DB_ONE    = DB_W'(1);
    localparam logic [DB_W-1:0]  DB_MAX    = DB_W'(DB_CYCLES);
    localparam logic [ST_W-1:0]  ST_ZERO   = {ST_W{1'b0}};
    localparam logic [ST_W-1:0]  ST_ONE    = ST_W'(1);
    localparam logic [ST_W-1:0]  STEP_LAST = ST_W'(STEP_CYCLES - 1);
    localparam logic [LED_W-1:0] LED_OFF   = {LED_W{1'b0}};
    localparam logic [LED_W-1:0] LED_FIRST = {{(LED_W-1){1'b0}}, 1'b1};
    localparam logic [LED_W-1:0] LED_LAST  = {1'b1, {(LED_W-1){1'b0}}};

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN_L = 2'b01,
        ST_RUN_R = 2'b10,
        ST_PAUSE = 2'b11
    } state_t;

    // Rotate the light one position towards the MSB; the MSB wraps to bit 0.
    function automatic logic [LED_W-1:0] rot_left(input logic [LED_W-1:0] v);
        rot_left = {v[LED_W-2:0], v[LED_W-1]};
    endfunction

    // Rotate the light one position towards the LSB; bit 0 wraps to the MSB.
    function automatic logic [LED_W-1:0] rot_right(input logic [LED_W-1:0] v);
        rot_right = {v[0], v[LED_W-1:1]};
    endfunction

    logic [1:0]      sync1_r;
    logic [1:0]      sync2_r;
    logic [1:0]      stable_r;
    logic [1:0]      stable_d_r;
    logic [DB_W-1:0] db_cnt_r [2];
    logic [1:0]      press_s;
    logic            tick_s;

    state_t          state_r;
    logic [LED_W-1:0] led_r;
    logic            dir_r;
    logic [ST_W-1:0] step_cnt_r;

    // Two-flop synchroniser for the asynchronous key inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 2'b00;
            sync2_r <= 2'b00;
        end else begin
            sync1_r <= key;
            sync2_r <= sync1_r;
        end
    end

    // Debounce: a level change is accepted only after DB_CYCLES consecutive
    // cycles of disagreement between synchronised and stable level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_r[0] <= DB_ZERO;
            db_cnt_r[1] <= DB_ZERO;
            stable_r    <= 2'b00;
            stable_d_r  <= 2'b00;
        end else begin
            stable_d_r <= stable_r;
            for (int i = 0; i < 2; i++) begin
                if (sync2_r[i] == stable_r[i]) begin
                    db_cnt_r[i] <= DB_ZERO;
                end else if (db_cnt_r[i] == DB_MAX) begin
                    stable_r[i] <= sync2_r[i];
                    db_cnt_r[i] <= DB_ZERO;
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + DB_ONE;
                end
            end
        end
    end

    // One-cycle press pulses on a debounced 0->1 edge; releases are ignored.
    always_comb begin
        press_s = stable_r & ~stable_d_r;
    end

    // Step tick: last count of the step period (only acted on in RUN states).
    always_comb begin
        tick_s = (step_cnt_r == STEP_LAST);
    end

    // Main FSM with registered led, direction memory and step timer.
    // A simultaneous press of both keys overrides everything; any press
    // overrides a step that falls in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            led_r      <= LED_OFF;
            dir_r      <= DIR_LEFT;
            step_cnt_r <= ST_ZERO;
        end else if (press_s == 2'b11) begin
            state_r    <= ST_IDLE;
            led_r      <= LED_OFF;
            step_cnt_r <= ST_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    step_cnt_r <= ST_ZERO;
                    if (press_s[0]) begin
                        state_r <= ST_RUN_L;
                        led_r   <= LED_FIRST;
                    end else if (press_s[1]) begin
                        state_r <= ST_RUN_R;
                        led_r   <= LED_LAST;
                    end else begin
                        led_r   <= LED_OFF;
                    end
                end
                ST_RUN_L: begin
                    if (press_s[0]) begin
                        state_r    <= ST_RUN_R;
                        step_cnt_r <= ST_ZERO;
                    end else if (press_s[1]) begin
                        state_r    <= ST_PAUSE;
                        dir_r      <= DIR_LEFT;
                        step_cnt_r <= ST_ZERO;
                    end else if (tick_s) begin
                        led_r      <= rot_left(led_r);
                        step_cnt_r <= ST_ZERO;
                    end else begin
                        step_cnt_r <= step_cnt_r + ST_ONE;
                    end
                end
                ST_RUN_R: begin
                    if (press_s[0]) begin
                        state_r    <= ST_RUN_L;
                        step_cnt_r <= ST_ZERO;
                    end else if (press_s[1]) begin
                        state_r    <= ST_PAUSE;
                        dir_r      <= DIR_RIGHT;
                        step_cnt_r <= ST_ZERO;
                    end else if (tick_s) begin
                        led_r      <= rot_right(led_r);
                        step_cnt_r <= ST_ZERO;
                    end else begin
                        step_cnt_r <= step_cnt_r + ST_ONE;
                    end
                end
                ST_PAUSE: begin
                    step_cnt_r <= ST_ZERO;
                    if (press_s[1]) begin
                        state_r <= (dir_r == DIR_RIGHT) ? ST_RUN_R : ST_RUN_L;
                    end else if (press_s[0]) begin
                        state_r <= ST_IDLE;
                        led_r   <= LED_OFF;
                    end else begin
                        state_r <= ST_PAUSE;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    led_r      <= LED_OFF;
                    dir_r      <= DIR_LEFT;
                    step_cnt_r <= ST_ZERO;
                end
            endcase
        end
    end

    assign led   = led_r;
    assign state = state_r;

endmodule

// File: tb/tb_led_run_ctrl.sv
// Directed bench for led_run_ctrl with LED_W=10, DB_CYCLES=4, STEP_CYCLES=8.
// Inputs change and outputs are sampled on the falling clock edge.
// A key set at a falling edge is first sampled at the next rising edge
// ("edge 0"); the FSM reacts at edge 7 and the first step follows 8 edges later.
module tb_led_run_ctrl;

    logic       clk;
    logic       rst_n;
    logic [1:0] key;
    logic [9:0] led;
    logic [1:0] state;

    int check_cnt = 0;
    int pass_cnt  = 0;

    led_run_ctrl #(
        .LED_W      (10),
        .DB_CYCLES  (4),
        .STEP_CYCLES(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .key  (key),
        .led  (led),
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Press for 8 cycles (through the FSM reaction edge), then release.
    task automatic press_key(input logic [1:0] k);
        key = k;
        cyc(8);
        key = 2'b00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        key   = 2'b00;
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        key   = 2'b00;
        cyc(3);
        check_cnt++;
        if ({state, led} !== {2'b00, 10'h000}) $display("FAIL reset_state: got state=%b led=%b, expected state=00 led=0000000000", state, led);
        else pass_cnt++;
        rst_n = 1'b1;
        cyc(3);
        check_cnt++;
        if ({state, led} !== {2'b00, 10'h000}) $display("FAIL reset_release: got state=%b led=%b, expected state=00 led=0000000000", state, led);
        else pass_cnt++;
        press_key(2'b01);
        check_cnt++;
        if ({state, led} !== {2'b01, 10'h001}) $display("FAIL reset_pre_run: got state=%b led=%b, expected state=01 led=0000000001", state, led);
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        check_cnt++;
        if ({state, led} !== {2'b00, 10'h000}) $display("FAIL reset_async: got state=%b led=%b, expected state=00 led=0000000000", state, led);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(5);
        check_cnt++;
        if ({state, led} !== {2'b00, 10'h000}) $display("FAIL reset_stay_idle: got state=%b led=%b, expected state=00 led=0000000000", state, led);
        else pass_cnt++;
    endtask

    task automatic test_go_left();
        key = 2'b01;
        cyc(7);
        check_cnt++;
        if ({state, led} !== {2'b00, 10'h000}) $display("FAIL go_before_edge7: got state=%b led=%b, expected state=00 led=0000000000", state, led);
        else pass_cnt++;
        cyc(1);
        check_cnt++;
        if ({state, led} !== {2'b01, 10'h001}) $display("FAIL go_edge7: got state=%b led=%b, expected state=01 led=0000000001", state, led);
        else pass_cnt++;
        cyc(7);
        check_cnt++;
        if ({state, led} !== {2'b01, 10'h001}) $display("FAIL step_early: got state=%b led=%b, expected state=01 led=0000000001", state, led);
        else pass_cnt++;
        cyc(1);
        check_cnt++;
        if ({state, led} !== {2'b01, 10'h002}) $display("FAIL first_step: got state=%b led=%b, expected state=01 led=0000000010", state, led);
        else pass_cnt++;
        cyc(4);
        check_cnt++;
        if ({state, led} !== {2'b01, 10'h002}) $display("FAIL held_no_repeat: got state=%b led=%b, expected state=01 led=0000000010", state, led);
        else pass_cnt++;
        key = 2'b00;
        cyc(60);
        check_cnt++;
        if ({state, led} !== {2'b01, 10'h200}) $display("FAIL left_msb: got state=%b led=%b, expected state=01 led=1000000000", state, led);
        else pass_cnt++;
        cyc(8);
        check_cnt++;
        if ({state, led} !== {2'b01, 10'h001}) $display("FAIL left_wrap: got state=%b led=%b, expected state=01 led=0000000001", state, led);
        else pass_cnt++;
        // This press lands on the same edge as a tick: the transition wins.
        press_key(2'b01);
        check_cnt++;
        if ({state, led} !== {2'b10, 10'h001}) $display("FAIL press_beats_tick: got state=%b led=%b, expected state=10 led=0000000001", state, led);
        else pass_cnt++;
        cyc(7);
        check_cnt++;
        if ({state, led} !== {2'b10, 10'h001}) $display("FAIL right_early: got state=%b led=%b, expected state=10 led=0000000001", state, led);
        else pass_cnt++;
        cyc(1);
        check_cnt++;
        if ({state, led} !== {2'b10, 10'h200}) $display("FAIL right_wrap: got state=%b led=%b, expected state=10 led=1000000000", state, led);
        else pass_cnt++;
    endtask

    task automatic test_both();
        do_reset();
        press_key(2'b01);
        cyc(8);
        press_key(2'b10);
        check_cnt++;
        if ({state, led} !== {2'b11, 10'h002}) $display("FAIL pause_from_left: got state=%b led=%b, expected state=11 led=0000000010", state, led);
        else pass_cnt++;
        cyc(8);
        press_key(2'b10);
        check_cnt++;
        if ({state, led} !== {2'b01, 10'h002}) $display("FAIL resume_left: got state=%b led=%b, expected state=01 led=0000000010", state, led);
        else pass_cnt++;
        cyc(8);
        check_cnt++;
        if ({state, led} !== {2'b01, 10'h004}) $display("FAIL resume_left_step: got state=%b led=%b, expected state=01 led=0000000100", state, led);
        else pass_cnt++;
        press_key(2'b11);
        check_cnt++;
        if ({state, led} !== {2'b00, 10'h000}) $display("FAIL both_to_idle: got state=%b led=%b, expected state=00 led=0000000000", state, led);
        else pass_cnt++;
    endtask

    task automatic test_glitch_right();
        cyc(8);
        key = 2'b01;
        cyc(3);
        key = 2'b00;
        cyc(16);
        check_cnt++;
        if ({state, led} !== {2'b00, 10'h000}) $display("FAIL glitch_ignored: got state=%b led=%b, expected state=00 led=0000000000", state, led);
        else pass_cnt++;
        press_key(2'b10);
        check_cnt++;
        if ({state, led} !== {2'b10, 10'h200}) $display("FAIL idle_to_right: got state=%b led=%b, expected state=10 led=1000000000", state, led);
        else pass_cnt++;
    endtask

    task automatic test_pause();
        cyc(8);
        check_cnt++;
        if ({state, led} !== {2'b10, 10'h100}) $display("FAIL right_step: got state=%b led=%b, expected state=10 led=0100000000", state, led);
        else pass_cnt++;
        press_key(2'b10);
        check_cnt++;
        if ({state, led} !== {2'b11, 10'h100}) $display("FAIL pause_from_right: got state=%b led=%b, expected state=11 led=0100000000", state, led);
        else pass_cnt++;
        cyc(15);
        check_cnt++;
        if ({state, led} !== {2'b11, 10'h100}) $display("FAIL pause_frozen_a: got state=%b led=%b, expected state=11 led=0100000000", state, led);
        else pass_cnt++;
        cyc(15);
        check_cnt++;
        if ({state, led} !== {2'b11, 10'h100}) $display("FAIL pause_frozen_b: got state=%b led=%b, expected state=11 led=0100000000", state, led);
        else pass_cnt++;
        press_key(2'b10);
        check_cnt++;
        if ({state, led} !== {2'b10, 10'h100}) $display("FAIL resume_right: got state=%b led=%b, expected state=10 led=0100000000", state, led);
        else pass_cnt++;
        cyc(7);
        check_cnt++;
        if ({state, led} !== {2'b10, 10'h100}) $display("FAIL resume_step_early: got state=%b led=%b, expected state=10 led=0100000000", state, led);
        else pass_cnt++;
        cyc(1);
        check_cnt++;
        if ({state, led} !== {2'b10, 10'h080}) $display("FAIL resume_step_8: got state=%b led=%b, expected state=10 led=0010000000", state, led);
        else pass_cnt++;
    endtask

    task automatic test_pause_to_idle();
        cyc(8);
        check_cnt++;
        if ({state, led} !== {2'b10, 10'h040}) $display("FAIL right_step2: got state=%b led=%b, expected state=10 led=0001000000", state, led);
        else pass_cnt++;
        press_key(2'b10);
        check_cnt++;
        if ({state, led} !== {2'b11, 10'h040}) $display("FAIL pause_again: got state=%b led=%b, expected state=11 led=0001000000", state, led);
        else pass_cnt++;
        cyc(8);
        press_key(2'b01);
        check_cnt++;
        if ({state, led} !== {2'b00, 10'h000}) $display("FAIL pause_go_idle: got state=%b led=%b, expected state=00 led=0000000000", state, led);
        else pass_cnt++;
        cyc(20);
        check_cnt++;
        if ({state, led} !== {2'b00, 10'h000}) $display("FAIL idle_stays: got state=%b led=%b, expected state=00 led=0000000000", state, led);
        else pass_cnt++;
    endtask

    initial begin
        rst_n = 1'b0;
        key   = 2'b00;
        test_reset();
        test_go_left();
        test_both();
        test_glitch_right();
        test_pause();
        test_pause_to_idle();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
